// File: rtl/profiler_uart_reporter.sv
// profiler_uart_reporter: snapshots the eight cache profiler counters every
// REPORT_INTERVAL cycles and streams them as one framed byte packet to the UART TX.
// Latency: the first header byte is presented on the tick edge. After that, one byte per cycle while tx_ready is high.
// Backpressure: each byte is held stable until tx_valid && tx_ready. A tick that arrives while a frame is in flight is dropped and counted.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   enable                   gates the interval timer (low: timer held at 0, no new frames)
//   *_counter (x8)           live profiler counters, sampled only on a tick in IDLE
//   tx_data/tx_valid/tx_ready  byte stream to the UART transmitter
//   report_busy              high whenever a frame is being sent
//   frame_count              frames fully sent, wraps modulo 2^16
//   overrun_count            ticks dropped while busy, saturates at 255
//
// Frame: A5 5A, then slots 0..7 (ihit, imiss, ireq, dhit, dmiss, dreq, ilat, dlat),
// each slot MSB first.
// Build option PROFILER_REPORT_CHECKSUM_EN appends the XOR of the 32 payload bytes.
module profiler_uart_reporter #(
    parameter int unsigned REPORT_INTERVAL = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] icache_hit_counter,
    input  logic [31:0] icache_miss_counter,
    input  logic [31:0] icache_request_counter,
    input  logic [31:0] dcache_hit_counter,
    input  logic [31:0] dcache_miss_counter,
    input  logic [31:0] dcache_request_counter,
    input  logic [31:0] icache_line_fill_latency_counter,
    input  logic [31:0] dcache_line_fill_latency_counter,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        report_busy,
    output logic [15:0] frame_count,
    output logic [7:0]  overrun_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR0    = 3'd1;
    localparam logic [2:0] S_HDR1    = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
`ifdef PROFILER_REPORT_CHECKSUM_EN
    localparam logic [2:0] S_CSUM    = 3'd4;
`endif

    localparam logic [31:0] TICK_AT = 32'(REPORT_INTERVAL - 1);

    logic [2:0]       state_q, state_d;
    logic [31:0]      tmr_q, tmr_d;
    logic [4:0]       idx_q, idx_d;
    logic [7:0][31:0] shadow_q, shadow_d;
    logic [7:0]       data_q, data_d;
    logic             vld_q, vld_d;
    logic [15:0]      fc_q, fc_d;
    logic [7:0]       ovr_q, ovr_d;
`ifdef PROFILER_REPORT_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic       xfer;
    logic       tick;
    logic [4:0] nxt_idx;

    // Byte i of the payload: slot i[4:2], MSB first within the slot.
    function automatic logic [7:0] pick_byte(input logic [7:0][31:0] sh, input logic [4:0] i);
        logic [31:0] w;
        w = sh[i[4:2]];
        case (i[1:0])
            2'd0:    pick_byte = w[31:24];
            2'd1:    pick_byte = w[23:16];
            2'd2:    pick_byte = w[15:8];
            default: pick_byte = w[7:0];
        endcase
    endfunction

    always_comb begin
        xfer    = vld_q && tx_ready;
        tick    = enable && (tmr_q == TICK_AT);
        tmr_d   = (!enable || tick) ? 32'd0 : tmr_q + 32'd1;
        nxt_idx = idx_q + 5'd1;

        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        vld_d    = vld_q;
        fc_d     = fc_q;
        ovr_d    = ovr_q;
`ifdef PROFILER_REPORT_CHECKSUM_EN
        csum_d   = csum_q;
`endif

        // Busy is judged on the current state, so a tick coinciding with the
        // final transfer of a frame is an overrun, not a new frame.
        if (tick && state_q != S_IDLE && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end

        // data_q always holds the byte currently being presented. On a transfer
        // the next byte is loaded on the same edge, so a ready sink sees one byte per cycle.
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    shadow_d = {dcache_line_fill_latency_counter,
                                icache_line_fill_latency_counter,
                                dcache_request_counter,
                                dcache_miss_counter,
                                dcache_hit_counter,
                                icache_request_counter,
                                icache_miss_counter,
                                icache_hit_counter};
                    state_d  = S_HDR0;
                    vld_d    = 1'b1;
                    data_d   = 8'hA5;
`ifdef PROFILER_REPORT_CHECKSUM_EN
                    csum_d   = 8'h00;
`endif
                end
            end
            S_HDR0: begin
                if (xfer) begin
                    state_d = S_HDR1;
                    data_d  = 8'h5A;
                end
            end
            S_HDR1: begin
                if (xfer) begin
                    state_d = S_PAYLOAD;
                    idx_d   = 5'd0;
                    data_d  = pick_byte(shadow_q, 5'd0);
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
`ifdef PROFILER_REPORT_CHECKSUM_EN
                    csum_d = csum_q ^ data_q;
`endif
                    if (idx_q == 5'd31) begin
`ifdef PROFILER_REPORT_CHECKSUM_EN
                        // Fold the final payload byte straight into the presented checksum.
                        state_d = S_CSUM;
                        data_d  = csum_q ^ data_q;
`else
                        state_d = S_IDLE;
                        vld_d   = 1'b0;
                        data_d  = 8'h00;
                        fc_d    = fc_q + 16'd1;
`endif
                    end else begin
                        idx_d  = nxt_idx;
                        data_d = pick_byte(shadow_q, nxt_idx);
                    end
                end
            end
`ifdef PROFILER_REPORT_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                    data_d  = 8'h00;
                    fc_d    = fc_q + 16'd1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
                data_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tmr_q    <= 32'd0;
            idx_q    <= 5'd0;
            shadow_q <= '0;
            data_q   <= 8'h00;
            vld_q    <= 1'b0;
            fc_q     <= 16'd0;
            ovr_q    <= 8'd0;
`ifdef PROFILER_REPORT_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            fc_q     <= fc_d;
            ovr_q    <= ovr_d;
`ifdef PROFILER_REPORT_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign tx_data       = data_q;
    assign tx_valid      = vld_q;
    assign report_busy   = (state_q != S_IDLE);
    assign frame_count   = fc_q;
    assign overrun_count = ovr_q;

endmodule

// File: tb/tb_profiler_uart_reporter.sv
// tb_profiler_uart_reporter: randomized bench for profiler_uart_reporter.
// Reference: a queue of the bytes still owed to the UART, plus interval and count bookkeeping.
// Inputs change 1 ns after each rising edge. Outputs are compared 1 ns after each rising edge.
module tb_profiler_uart_reporter;

    localparam int RI = 64;
`ifdef PROFILER_REPORT_CHECKSUM_EN
    localparam int FLEN = 35;
`else
    localparam int FLEN = 34;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] cnt [8];
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        report_busy;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;

    always #5 clk = ~clk;

    profiler_uart_reporter #(.REPORT_INTERVAL(RI)) dut (
        .clk                              (clk),
        .rst                              (rst),
        .enable                           (enable),
        .icache_hit_counter               (cnt[0]),
        .icache_miss_counter              (cnt[1]),
        .icache_request_counter           (cnt[2]),
        .dcache_hit_counter               (cnt[3]),
        .dcache_miss_counter              (cnt[4]),
        .dcache_request_counter           (cnt[5]),
        .icache_line_fill_latency_counter (cnt[6]),
        .dcache_line_fill_latency_counter (cnt[7]),
        .tx_data                          (tx_data),
        .tx_valid                         (tx_valid),
        .tx_ready                         (tx_ready),
        .report_busy                      (report_busy),
        .frame_count                      (frame_count),
        .overrun_count                    (overrun_count)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state.
    logic [7:0] mq [$];   // bytes still to be sent; the head is the byte on the bus
    int         m_tmr = 0;
    int         m_fc  = 0;
    int         m_ovr = 0;
    int         m_sent = 0;   // bytes already transferred in the current frame

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic build_frame();
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        mq.push_back(8'hA5);
        mq.push_back(8'h5A);
        for (int s = 0; s < 8; s++) begin
            for (int k = 3; k >= 0; k--) begin
                b = cnt[s][8*k +: 8];
                mq.push_back(b);
                cs = cs ^ b;
            end
        end
`ifdef PROFILER_REPORT_CHECKSUM_EN
        mq.push_back(cs);
`endif
    endtask

    // Advance one clock, update the model from the inputs the DUT sampled, and compare.
    task automatic step();
        bit busy;
        bit tick;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_tmr = 0; m_fc = 0; m_ovr = 0; m_sent = 0;
        end else begin
            busy = (mq.size() != 0);
            if (busy && tx_ready) begin
                void'(mq.pop_front());
                m_sent++;
                if (mq.size() == 0) begin
                    m_fc = (m_fc + 1) % 65536;
                    m_sent = 0;
                end
            end
            tick = 1'b0;
            if (enable) begin
                if (m_tmr == RI - 1) begin tick = 1'b1; m_tmr = 0; end
                else m_tmr++;
            end else begin
                m_tmr = 0;
            end
            if (tick) begin
                if (busy) begin
                    if (m_ovr < 255) m_ovr++;
                end else begin
                    build_frame();
                end
            end
        end
        #1;
        chk("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
        chk("report_busy", 32'(report_busy), 32'(mq.size() != 0));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
        chk("overrun_count", 32'(overrun_count), 32'(m_ovr));
        if (mq.size() != 0) chk("tx_data", 32'(tx_data), 32'(mq[0]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; tx_ready = 1'b0;
        run(2);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        rst = 1'b0;
    endtask

    task automatic rand_cnt();
        for (int s = 0; s < 8; s++) cnt[s] = $urandom;
    endtask

    // Wait for the model to start a frame.
    task automatic wait_frame_start(input int budget);
        int i;
        i = 0;
        while (mq.size() == 0 && i < budget) begin step(); i++; end
        if (mq.size() == 0) chk("timeout_frame_start", 32'h0, 32'h1);
    endtask

    // Wait until k bytes of the current frame have been transferred.
    task automatic wait_sent(input int k, input int budget);
        int i;
        i = 0;
        while (m_sent < k && i < budget) begin
            tx_ready = 1'($urandom);
            step(); i++;
        end
        if (m_sent < k) chk("timeout_wait_sent", 32'h0, 32'h1);
    endtask

    initial begin
        int n;
        for (int s = 0; s < 8; s++) cnt[s] = 32'h0;

        // 1: basic frame with a fixed slot pattern and a sink that is always ready.
        do_reset();
        for (int s = 0; s < 8; s++) cnt[s] = 32'h11111111 * (s + 1);
        enable = 1'b1; tx_ready = 1'b1;
        n = 0;
        while (!tx_valid && n < 200) begin step(); n++; end
        chk("first_valid_cycle", 32'(n), 32'd64);
        n = 1;
        while (tx_valid && n < 100) begin step(); n++; end
        chk("frame_len", 32'(n - 1), 32'(FLEN));
        chk("basic_frame_count", 32'(frame_count), 32'd1);

        // 2: the sink toggles ready every cycle.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 2 * RI + 40; i++) begin
            tx_ready = ~tx_ready;
            step();
        end

        // 3: overrun. The sink stalls for 200 cycles after the first tick, then the inputs change.
        do_reset();
        rand_cnt();
        enable = 1'b1;
        wait_frame_start(200);
        run(200);
        chk("overrun_3", 32'(overrun_count), 32'd3);
        rand_cnt();
        tx_ready = 1'b1;
        run(60);

        // 4: all inputs change one cycle after the tick. The frame in flight keeps the snapshot.
        do_reset();
        rand_cnt();
        enable = 1'b1; tx_ready = 1'b1;
        wait_frame_start(200);
        for (int s = 0; s < 8; s++) cnt[s] = 32'hDEADBEEF;
        run(2 * RI + 20);

        // 5: reset asserted at payload byte 10.
        do_reset();
        rand_cnt();
        enable = 1'b1;
        wait_frame_start(200);
        wait_sent(12, 500);
        rst = 1'b1;
        step();
        chk("midrst_valid", 32'(tx_valid), 32'h0);
        chk("midrst_fc", 32'(frame_count), 32'h0);
        rst = 1'b0; tx_ready = 1'b1;
        n = 0;
        while (!tx_valid && n < 200) begin step(); n++; end
        chk("after_rst_valid_cycle", 32'(n), 32'd64);
        chk("after_rst_first_byte", 32'(tx_data), 32'hA5);
        run(40);

        // 6: enable drops at payload byte 5.
        do_reset();
        rand_cnt();
        enable = 1'b1;
        wait_frame_start(200);
        wait_sent(7, 500);
        enable = 1'b0; tx_ready = 1'b1;
        run(500);
        chk("gate_fc", 32'(frame_count), 32'd1);
        chk("gate_ovr", 32'(overrun_count), 32'd0);

        // 7: the overrun counter saturates while the sink stalls for good.
        do_reset();
        rand_cnt();
        enable = 1'b1;
        run(RI * 260);
        chk("ovr_saturate", 32'(overrun_count), 32'd255);
        tx_ready = 1'b1;
        run(60);

        // 8: random soak.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            enable   = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) rand_cnt();
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
